// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons, count-tick prescaler and run/pause/lap/done FSM
// driving an external 4-digit BCD counter.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       cnt_full,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       hold,
  output logic       run_led,
  output logic       ovf,
  output logic [2:0] state
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_r, state_n;
  logic [3:0]     btn_raw;
  logic [3:0]     sync_p0, sync_p1;
  logic [3:0]     db_lvl, db_lvl_d;
  logic [CW-1:0]  db_cnt [4];
  logic [3:0]     press;
  logic [PW-1:0]  presc;
  logic           run_like, tick;
  logic           ev_clear, win_stop, win_start, win_lap;

  // bit order: 0 start, 1 stop, 2 clear, 3 lap
  assign btn_raw = {btn_lap, btn_clear, btn_stop, btn_start};

  // stage p0/p1: two-flop synchronizer, then per-button debounce counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          db_lvl[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = db_lvl & ~db_lvl_d;

  // only the highest-priority event of a cycle is acted on: clear > stop > start > lap
  assign ev_clear  = press[2];
  assign win_stop  = press[1] & ~ev_clear;
  assign win_start = press[0] & ~press[1] & ~ev_clear;
  assign win_lap   = press[3] & ~press[0] & ~press[1] & ~ev_clear;

  assign run_like = (state_r == S_RUN) || (state_r == S_LAP);
  assign tick     = run_like && (presc == PW'(TICK_DIV - 1));

  always_comb begin
    state_n = state_r;
    if (ev_clear) begin
      state_n = S_IDLE;
    end else if (tick && cnt_full) begin
      state_n = S_DONE;
    end else begin
      unique case (state_r)
        S_IDLE:  if (win_start) state_n = S_RUN;
        S_RUN: begin
          if (win_stop)     state_n = S_PAUSE;
          else if (win_lap) state_n = S_LAP;
        end
        S_PAUSE: if (win_start) state_n = S_RUN;
        S_LAP: begin
          if (win_stop)     state_n = S_PAUSE;
          else if (win_lap) state_n = S_RUN;
        end
        S_DONE:  state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // stage p2: state, prescaler and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      hold    <= 1'b0;
      run_led <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_r <= state_n;
      if (state_n == S_IDLE)
        presc <= '0;
      else if (tick)
        presc <= '0;
      else if (run_like)
        presc <= presc + PW'(1);
      cnt_en  <= tick & ~cnt_full & ~ev_clear;
      cnt_clr <= ev_clear;
      hold    <= (state_n == S_LAP);
      run_led <= (state_n == S_RUN) || (state_n == S_LAP);
      ovf     <= (state_n == S_DONE);
    end
  end

  assign state = state_r;

endmodule
